cache_ctrl_dm: RTL and testbench
================================

// Module: cache_ctrl_dm
// PURPOSE
//  Parametrised direct-mapped, write-through, no-write-allocate data cache for the pipelined core's MEM stage.
//  Sits between the ex_mem register and the SRAM controller; multi-word line refill; asserts stall to freeze pipeline.
//  Replaces the fixed-geometry cache controller; geometry, data width and line size are now parameters.
// PARAMETERS
//  DATA_W     16  word width (bits)
//  ADDR_W     18  word address width
//  LINES      64  number of lines, power of 2; IDX_W = log2(LINES)
//  LINE_WORDS 4   words per line, power of 2 >= 1; OFF_W = log2(LINE_WORDS); TAG_W = ADDR_W-IDX_W-OFF_W
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  cpu_rd_en  in   1        load request (held while stall=1)
//  cpu_wr_en  in   1        store request (held while stall=1)
//  cpu_addr   in   ADDR_W   word address {tag,idx,off}
//  cpu_wdata  in   DATA_W   store data
//  cpu_rdata  out  DATA_W   load data, valid when cpu_rd_en & ~stall
//  stall      out  1        1 = freeze pipeline (combinational)
//  mem_req    out  1        SRAM controller request, held until mem_done
//  mem_we     out  1        1 = write, 0 = read
//  mem_addr   out  ADDR_W   SRAM word address
//  mem_wdata  out  DATA_W   SRAM write data
//  mem_rdata  in   DATA_W   SRAM read data, valid with mem_done
//  mem_done   in   1        one-cycle completion pulse per word
//  mon_sel    in   IDX_W    monitor line select
//  mon_data   out  DATA_W   word 0 of selected line (0 if invalid)
//  hit_cnt    out  16       read-hit counter (see CONFIGURATION)
//  miss_cnt   out  16       read-miss counter
// BEHAVIOUR
//  - Reset: all valid bits cleared in one cycle; FSM=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0; stall follows inputs.
//  - FSM states IDLE, REFILL, WRITE.
//  - IDLE, read hit (valid & tag match): cpu_rdata = line word same cycle, stall=0, zero added latency.
//  - IDLE, read miss: stall=1 same cycle; next edge -> REFILL, mem_req=1, mem_we=0, mem_addr={tag,idx,OFF_W'0}.
//  - REFILL: word counter 0..LINE_WORDS-1; on each mem_done store mem_rdata in word[cnt], mem_addr offset +1.
//    On last mem_done: set tag, valid=1, drop mem_req, -> IDLE; held request then hits (stall=0 that cycle).
//    Valid bit stays 0 during refill; stall=1 throughout.
//  - IDLE, write: stall=1; next edge -> WRITE, mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
//    Hit: cache word updated at the same edge. Miss: no allocate, cache unchanged.
//    On mem_done: drop mem_req, -> IDLE with stall=0 that cycle (store retires).
//  - rd_en & wr_en both 1: write wins, read ignored.
//  - Neither enable: stall=0, no state change, cpu_rdata = don't-care (driven from array).
//  - mem_done outside REFILL/WRITE: ignored.
//  - rst mid-REFILL/WRITE: abort at that edge; mem_req=0 next cycle; partial line discarded (valid=0).
//  - Address offset wrap inside refill: counter wraps within line only; idx/tag never change mid-refill.
// CONFIGURATION
//  CACHE_STATS_EN defined: hit_cnt +1 per read hit accepted (stall=0), miss_cnt +1 per IDLE->REFILL.
//    Both saturate at 16'hFFFF; cleared by rst.
//  CACHE_STATS_EN undefined: hit_cnt = miss_cnt = 16'h0000, no counter flops; all other behaviour identical.
// TESTING
//  - rst held 1 cycle, then read 0x00010 -> stall=1; one mem_req, mem_addr 0x00010..0x00013, 4 done pulses; next cycle stall=0, rdata=SRAM[0x00010].
//  - After fill, read 0x00012 -> stall=0 same cycle, rdata=SRAM[0x00012]; no mem_req; hit_cnt +1 (with CACHE_STATS_EN).
//  - Write 0xBEEF to 0x00011 (hit) -> mem_we=1, mem_addr=0x00011; after done, read 0x00011 hits with 0xBEEF.
//  - Write 0x1234 to 0x00100 (miss, no allocate) -> SRAM updated; then read 0x00100 misses, refills, returns 0x1234.
//  - Conflict: read 0x00010, then 0x01010 (same idx, different tag) -> second misses; 0x00010 then misses again; miss_cnt=3.
//  - rst asserted after 2nd mem_done of a refill -> mem_req=0 next cycle; re-read same address misses, refills fully.

Source files
------------

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Optional read hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_ctrl_dm #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 18,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_rd_en,
  input  logic                       cpu_wr_en,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_done,
  input  logic [$clog2(LINES)-1:0]   mon_sel,
  output logic [DATA_W-1:0]          mon_data,
  output logic [15:0]                hit_cnt,
  output logic [15:0]                miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int LOW_W = IDX_W + OFF_W;
  localparam int TAG_W = ADDR_W - LOW_W;
  localparam int WORDS = LINES * LINE_WORDS;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] data_mem [WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;

  logic [TAG_W-1:0] cpu_tag, mem_tag;
  logic [IDX_W-1:0] cpu_idx, mem_idx;
  logic [LOW_W-1:0] cpu_word, mem_word, mon_word;
  logic             hit, refill_last;

  assign cpu_tag  = cpu_addr[ADDR_W-1:LOW_W];
  assign cpu_idx  = cpu_addr[LOW_W-1:OFF_W];
  assign cpu_word = cpu_addr[LOW_W-1:0];
  assign mem_tag  = mem_addr[ADDR_W-1:LOW_W];
  assign mem_idx  = mem_addr[LOW_W-1:OFF_W];
  assign mem_word = mem_addr[LOW_W-1:0];
  assign mon_word = LOW_W'(mon_sel) << OFF_W;

  assign hit         = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  // The offset bits of mem_addr double as the refill word counter.
  assign refill_last = (mem_addr & OFF_MASK) == OFF_MASK;

  assign cpu_rdata = data_mem[cpu_word];
  assign mon_data  = valid[mon_sel] ? data_mem[mon_word] : '0;

  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_wr_en) begin
          stall      = 1'b1;
          next_state = WRITE;
        end else if (cpu_rd_en && !hit) begin
          stall      = 1'b1;
          next_state = REFILL;
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (mem_done && refill_last) next_state = IDLE;
      end
      WRITE: begin
        // The store retires in the completion cycle itself.
        stall = ~mem_done;
        if (mem_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid     <= '0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE: begin
          if (cpu_wr_en) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
          end else if (cpu_rd_en && !hit) begin
            mem_req        <= 1'b1;
            mem_we         <= 1'b0;
            mem_addr       <= cpu_addr & ~OFF_MASK;
            valid[cpu_idx] <= 1'b0;
          end
        end
        REFILL: begin
          if (mem_done) begin
            mem_addr <= (mem_addr & ~OFF_MASK) | ((mem_addr + ADDR_W'(1)) & OFF_MASK);
            if (refill_last) begin
              mem_req        <= 1'b0;
              valid[mem_idx] <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: data and tag arrays are not reset; cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && cpu_wr_en && hit)
        data_mem[cpu_word] <= cpu_wdata;
      if (state == REFILL && mem_done) begin
        data_mem[mem_word] <= mem_rdata;
        if (refill_last) tag_mem[mem_idx] <= mem_tag;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_q, miss_q;
  logic        hit_evt, miss_evt;

  assign hit_evt  = (state == IDLE) && cpu_rd_en && !cpu_wr_en && hit;
  assign miss_evt = (state == IDLE) && cpu_rd_en && !cpu_wr_en && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_evt && hit_q != 16'hFFFF)   hit_q  <= hit_q + 16'd1;
      if (miss_evt && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = 16'h0000;
  assign miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Self-checking bench for cache_ctrl_dm: directed vector table, reset-abort
// sequence and randomized accesses against an address-level reference model.
`timescale 1ns/1ps
module tb_cache_ctrl_dm;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 18;
  localparam int LINES      = 64;
  localparam int LINE_WORDS = 4;
  localparam int IDX_W      = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_rd_en, cpu_wr_en;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              stall, mem_req, mem_we, mem_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, mon_data;
  logic [IDX_W-1:0]  mon_sel;
  logic [15:0]       hit_cnt, miss_cnt;

  cache_ctrl_dm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mon_sel(mon_sel), .mon_data(mon_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Initial SRAM contents are a fixed function of the address.
  function automatic logic [15:0] init_val(input int a);
    return 16'((a * 40503) ^ 23100);
  endfunction

  // SRAM seen by the DUT and the bench's own reference copy, kept separately.
  logic [15:0] sram    [int];
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] sram_rd(input int a);
    return sram.exists(a) ? sram[a] : init_val(a);
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  txn_t txn_q[$];
  int   dones_taken = 0;

  // SRAM controller model: random 0..2 cycle latency, one-cycle done pulse per word.
  initial begin
    int lat;
    lat       = 0;
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_done) dones_taken++;
      mem_done = 1'b0;
      if (mem_req) begin
        if (lat == 0) begin
          txn_q.push_back('{mem_we, mem_addr, mem_wdata});
          if (mem_we) sram[int'(mem_addr)] = mem_wdata;
          else        mem_rdata = sram_rd(int'(mem_addr));
          mem_done = 1'b1;
          lat      = $urandom_range(0, 2);
        end else begin
          lat--;
        end
      end
    end
  end

  // Reference cache state: which tag each line holds, plus expected statistics.
  bit m_valid [LINES];
  int m_tag   [LINES];
  int exp_hits = 0, exp_misses = 0;

  function automatic logic [15:0] exp_hit_cnt();
`ifdef CACHE_STATS_EN
    return (exp_hits > 65535) ? 16'hFFFF : 16'(exp_hits);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] exp_miss_cnt();
`ifdef CACHE_STATS_EN
    return (exp_misses > 65535) ? 16'hFFFF : 16'(exp_misses);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  // Runs one CPU access from posedge+1 until it retires, checking against the model.
  task automatic access(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, output int cyc, output logic [DATA_W-1:0] rdata);
    int a, idx, tg, base;
    bit is_rd, exp_miss;
    a        = int'(addr);
    idx      = (a / LINE_WORDS) % LINES;
    tg       = a / (LINE_WORDS * LINES);
    base     = a - (a % LINE_WORDS);
    is_rd    = rd && !wr;
    exp_miss = is_rd && !(m_valid[idx] && m_tag[idx] == tg);
    txn_q.delete();
    cpu_rd_en = rd;
    cpu_wr_en = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cyc       = 0;
    rdata     = '0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cyc++;
      if (cyc > 100) begin
        check("timeout_stall", 32'(stall), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    rdata = cpu_rdata;

    if (is_rd) begin
      check("rd_stalled", 32'(cyc != 0), 32'(exp_miss));
      check("rd_data", 32'(cpu_rdata), 32'(ref_rd(a)));
      check("rd_txn_count", txn_q.size(), exp_miss ? LINE_WORDS : 0);
      for (int i = 0; i < txn_q.size() && i < LINE_WORDS; i++) begin
        check("refill_we", 32'(txn_q[i].we), 32'd0);
        check("refill_addr", 32'(txn_q[i].addr), 32'(base + i));
      end
    end else if (wr) begin
      check("wr_stalled", 32'(cyc != 0), 32'd1);
      check("wr_txn_count", txn_q.size(), 32'd1);
      if (txn_q.size() >= 1) begin
        check("wr_we", 32'(txn_q[0].we), 32'd1);
        check("wr_addr", 32'(txn_q[0].addr), 32'(a));
        check("wr_data", 32'(txn_q[0].wdata), 32'(wd));
      end
    end else begin
      check("idle_stall", 32'(cyc), 32'd0);
      check("idle_mem_req", 32'(mem_req), 32'd0);
    end

    if (wr) ref_mem[a] = wd;
    if (exp_miss) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      exp_misses++;
    end
    if (is_rd) exp_hits++;

    @(posedge clk); #1;
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    check("hit_cnt", 32'(hit_cnt), 32'(exp_hit_cnt()));
    check("miss_cnt", 32'(miss_cnt), 32'(exp_miss_cnt()));
  endtask

  task automatic check_mon(input int sel);
    logic [15:0] exp;
    exp = m_valid[sel] ? ref_rd(m_tag[sel] * LINES * LINE_WORDS + sel * LINE_WORDS) : 16'h0000;
    mon_sel = IDX_W'(sel);
    #1;
    check("mon_data", 32'(mon_data), 32'(exp));
  endtask

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic              exp_miss;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  initial begin
    vec_t              vecs[$];
    int                cyc;
    logic [DATA_W-1:0] rdata;

    vecs.push_back('{1'b1, 1'b0, 18'h00010, 16'h0000, 1'b1, init_val(32'h10)});
    vecs.push_back('{1'b1, 1'b0, 18'h00012, 16'h0000, 1'b0, init_val(32'h12)});
    vecs.push_back('{1'b0, 1'b1, 18'h00011, 16'hBEEF, 1'b0, 16'h0000});
    vecs.push_back('{1'b1, 1'b0, 18'h00011, 16'h0000, 1'b0, 16'hBEEF});
    vecs.push_back('{1'b0, 1'b1, 18'h00100, 16'h1234, 1'b0, 16'h0000});
    vecs.push_back('{1'b1, 1'b0, 18'h00100, 16'h0000, 1'b1, 16'h1234});
    vecs.push_back('{1'b1, 1'b0, 18'h00010, 16'h0000, 1'b0, init_val(32'h10)});
    vecs.push_back('{1'b1, 1'b0, 18'h01010, 16'h0000, 1'b1, init_val(32'h1010)});
    vecs.push_back('{1'b1, 1'b0, 18'h00010, 16'h0000, 1'b1, init_val(32'h10)});
    vecs.push_back('{1'b1, 1'b0, 18'h00012, 16'h0000, 1'b0, init_val(32'h12)});
    vecs.push_back('{1'b1, 1'b1, 18'h00013, 16'h7777, 1'b0, 16'h0000});
    vecs.push_back('{1'b1, 1'b0, 18'h00013, 16'h0000, 1'b0, 16'h7777});

    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mon_sel   = '0;
    rst       = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    check("rst_mon_data", 32'(mon_data), 32'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, cyc, rdata);
      if (vecs[i].rd && !vecs[i].wr) begin
        check("vec_miss", 32'(cyc != 0), 32'(vecs[i].exp_miss));
        check("vec_rdata", 32'(rdata), 32'(vecs[i].exp_data));
      end
    end
    check("sram_0x11", 32'(sram_rd(32'h11)), 32'hBEEF);
    check("sram_0x100", 32'(sram_rd(32'h100)), 32'h1234);
`ifdef CACHE_STATS_EN
    check("vec_hit_total", 32'(hit_cnt), 32'd9);
    check("vec_miss_total", 32'(miss_cnt), 32'd4);
`endif
    mon_sel = IDX_W'(4);
    #1;
    check("vec_mon_idx4", 32'(mon_data), 32'(init_val(32'h10)));
    mon_sel = IDX_W'(0);
    #1;
    check("vec_mon_idx0", 32'(mon_data), 32'h1234);
    mon_sel = IDX_W'(5);
    #1;
    check("vec_mon_idx5", 32'(mon_data), 32'd0);

    // Reset after the second refill word has been accepted.
    @(posedge clk); #1;
    txn_q.delete();
    dones_taken = 0;
    cpu_addr    = 18'h02000;
    cpu_rd_en   = 1'b1;
    cyc         = 0;
    while (dones_taken < 2 && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("abort_two_dones", 32'(dones_taken >= 2), 32'd1);
    check("abort_req_before", 32'(mem_req), 32'd1);
    rst       = 1'b1;
    cpu_rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_hit_cnt", 32'(hit_cnt), 32'd0);
    check("abort_miss_cnt", 32'(miss_cnt), 32'd0);
    model_reset();
    check_mon(0);
    check_mon(4);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 18'h02000, 16'h0000, cyc, rdata);
    check("abort_reread_miss", 32'(cyc != 0), 32'd1);
    check("abort_reread_data", 32'(rdata), 32'(init_val(32'h2000)));

    // Randomized accesses over a few tags and lines to mix hits, misses and conflicts.
    for (int n = 0; n < 300; n++) begin
      int mode, tg, idx, off;
      logic [ADDR_W-1:0] addr;
      mode = $urandom_range(0, 9);
      tg   = $urandom_range(0, 3);
      idx  = $urandom_range(0, 7);
      off  = $urandom_range(0, LINE_WORDS - 1);
      addr = ADDR_W'(tg * LINES * LINE_WORDS + idx * LINE_WORDS + off);
      case (mode)
        0:       access(1'b0, 1'b0, addr, 16'(n), cyc, rdata);
        1:       access(1'b1, 1'b1, addr, 16'($urandom), cyc, rdata);
        2, 3, 4: access(1'b0, 1'b1, addr, 16'($urandom), cyc, rdata);
        default: access(1'b1, 1'b0, addr, 16'h0000, cyc, rdata);
      endcase
      if (n % 25 == 0) check_mon($urandom_range(0, 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
